// File: rtl/pio_gpio.sv
// pio_gpio: parametrised Avalon-MM slave GPIO port.
//
// Provides WIDTH bits with a per-bit direction register and set/clear/toggle
// aliases of the output data register. Inputs are synchronised, edges are
// captured into a sticky write-1-to-clear register, and a maskable level
// interrupt is raised from the captured edges.
//
// Optional feature macro: PIO_BLINK_EN. When defined, address 7 holds a
// blink mask and masked output bits are gated by a free-running phase that
// toggles every BLINK_DIV clocks. When undefined, address 7 reads 0 and
// ignores writes.
//
// Ports:
//   clk        in   1      system clock
//   reset_n    in   1      asynchronous, active-low reset
//   address    in   3      word address
//   chipselect in   1      slave select
//   write_n    in   1      active-low write strobe
//   writedata  in   32     write data, bits [WIDTH-1:0] used
//   readdata   out  32     combinational read data, zero-extended
//   in_port    in   WIDTH  asynchronous pin inputs
//   out_port   out  WIDTH  pin output values
//   oe         out  WIDTH  per-bit output enable (direction register)
//   irq        out  1      registered level interrupt, active high
module pio_gpio #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_OUT = 32'h0,
    parameter logic [31:0] RESET_DIR = 32'h0,
    parameter int          EDGE_TYPE = 0,
    parameter int          BLINK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [WIDTH-1:0] RST_OUT = RESET_OUT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_DIR = RESET_DIR[WIDTH-1:0];

    logic             wr;
    logic [WIDTH-1:0] wd;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q,      dir_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] sync1_q,    sync1_d;
    logic [WIDTH-1:0] in_sync_q,  in_sync_d;
    logic [WIDTH-1:0] in_prev_q,  in_prev_d;
    logic             irq_q,      irq_d;

    // Upper write-data bits are unused when WIDTH < 32.
    logic unused_wd;
    assign unused_wd = ^writedata;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    function automatic logic [WIDTH-1:0] edge_term(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] prev);
        case (EDGE_TYPE)
            0:       return cur & ~prev;
            1:       return ~cur & prev;
            default: return cur ^ prev;
        endcase
    endfunction

`ifdef PIO_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0] blink_cnt_q,   blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [WIDTH-1:0] blink_mask_q,  blink_mask_d;

    always_comb begin
        blink_mask_d  = blink_mask_q;
        blink_phase_d = blink_phase_q;
        blink_cnt_d   = blink_cnt_q + CNT_W'(1);
        if (wr && address == 3'd7) blink_mask_d = wd;
        if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            blink_mask_q  <= '0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            blink_mask_q  <= blink_mask_d;
        end
    end

    // Masked bits follow data_out only while the phase is high.
    assign out_port = data_out_q & (~blink_mask_q | {WIDTH{blink_phase_q}});
`else
    logic unused_blink_div;
    assign unused_blink_div = (BLINK_DIV < 2);

    assign out_port = data_out_q;
`endif

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_mask_d = irq_mask_q;
        edge_cap_d = edge_cap_q;
        if (wr) begin
            case (address)
                3'd0:    data_out_d = wd;
                3'd1:    dir_d      = wd;
                3'd2:    irq_mask_d = wd;
                3'd3:    edge_cap_d = edge_cap_q & ~wd;
                3'd4:    data_out_d = data_out_q | wd;
                3'd5:    data_out_d = data_out_q & ~wd;
                3'd6:    data_out_d = data_out_q ^ wd;
                default: ;
            endcase
        end
        // Applied after the clear so a coincident edge keeps the bit set.
        edge_cap_d = edge_cap_d | edge_term(in_sync_q, in_prev_q);
        sync1_d    = in_port;
        in_sync_d  = sync1_q;
        in_prev_d  = in_sync_q;
        irq_d      = |(edge_cap_q & irq_mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RST_OUT;
            dir_q      <= RST_DIR;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            sync1_q    <= '0;
            in_sync_q  <= '0;
            in_prev_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            sync1_q    <= sync1_d;
            in_sync_q  <= in_sync_d;
            in_prev_q  <= in_prev_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata[WIDTH-1:0] = (dir_q & data_out_q) | (~dir_q & in_sync_q);
            3'd1:    readdata[WIDTH-1:0] = dir_q;
            3'd2:    readdata[WIDTH-1:0] = irq_mask_q;
            3'd3:    readdata[WIDTH-1:0] = edge_cap_q;
            3'd4:    readdata[WIDTH-1:0] = data_out_q;
            3'd5:    readdata[WIDTH-1:0] = data_out_q;
            3'd6:    readdata[WIDTH-1:0] = data_out_q;
`ifdef PIO_BLINK_EN
            default: readdata[WIDTH-1:0] = blink_mask_q;
`else
            default: readdata = '0;
`endif
        endcase
    end

    assign oe  = dir_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_pio_gpio.sv
module tb_pio_gpio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;

    logic [2:0][31:0] rd;
    logic [2:0][7:0]  op;
    logic [2:0][7:0]  oe_o;
    logic [2:0]       irq_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pio_gpio #(.WIDTH(8), .RESET_OUT(32'hA5), .RESET_DIR(32'h0), .EDGE_TYPE(0), .BLINK_DIV(4)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[0]), .in_port(in_port),
        .out_port(op[0]), .oe(oe_o[0]), .irq(irq_o[0]));
    pio_gpio #(.WIDTH(8), .RESET_OUT(32'hA5), .RESET_DIR(32'h0), .EDGE_TYPE(1), .BLINK_DIV(4)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[1]), .in_port(in_port),
        .out_port(op[1]), .oe(oe_o[1]), .irq(irq_o[1]));
    pio_gpio #(.WIDTH(8), .RESET_OUT(32'hA5), .RESET_DIR(32'h0), .EDGE_TYPE(2), .BLINK_DIV(4)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[2]), .in_port(in_port),
        .out_port(op[2]), .oe(oe_o[2]), .irq(irq_o[2]));

    // Reference model: register contents plus a history of sampled pins.
    // hist[k] is the pin value sampled k+1 clocks ago; in_sync is hist[1].
    logic [7:0] m_data, m_dir, m_mask, m_blink;
    logic [7:0] m_cap [3];
    logic       m_irq [3];
    logic [7:0] hist  [3];
    int         m_cycles;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [7:0]  exp_out;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data = 8'hA5; m_dir = 8'h00; m_mask = 8'h00; m_blink = 8'h00;
        m_cycles = 0;
        for (int t = 0; t < 3; t++) begin
            m_cap[t] = 8'h00; m_irq[t] = 1'b0; hist[t] = 8'h00;
        end
    endtask

    function automatic logic [7:0] m_edge(input int t, input logic [7:0] cur, input logic [7:0] prev);
        case (t)
            0:       return cur & ~prev;
            1:       return ~cur & prev;
            default: return cur ^ prev;
        endcase
    endfunction

    task automatic model_step();
        logic       w;
        logic [7:0] d;
        w = chipselect && !write_n;
        d = writedata[7:0];
        for (int t = 0; t < 3; t++) m_irq[t] = |(m_cap[t] & m_mask);
        for (int t = 0; t < 3; t++) begin
            if (w && address == 3'd3) m_cap[t] = m_cap[t] & ~d;
            m_cap[t] = m_cap[t] | m_edge(t, hist[1], hist[2]);
        end
        if (w) begin
            case (address)
                3'd0: m_data = d;
                3'd1: m_dir  = d;
                3'd2: m_mask = d;
                3'd4: m_data = m_data | d;
                3'd5: m_data = m_data & ~d;
                3'd6: m_data = m_data ^ d;
`ifdef PIO_BLINK_EN
                3'd7: m_blink = d;
`endif
                default: ;
            endcase
        end
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = in_port;
        m_cycles++;
    endtask

    function automatic logic [7:0] m_out();
`ifdef PIO_BLINK_EN
        logic ph;
        ph = ((m_cycles / 4) % 2) == 1;
        return m_data & (~m_blink | {8{ph}});
`else
        return m_data;
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a, input int t);
        logic [7:0] v;
        case (a)
            3'd0: v = (m_dir & m_data) | (~m_dir & hist[1]);
            3'd1: v = m_dir;
            3'd2: v = m_mask;
            3'd3: v = m_cap[t];
            3'd4, 3'd5, 3'd6: v = m_data;
`ifdef PIO_BLINK_EN
            default: v = m_blink;
`else
            default: v = 8'h00;
`endif
        endcase
        return {24'h0, v};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cycle(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic check_all();
        for (int t = 0; t < 3; t++) begin
            check("rand_out", {24'h0, op[t]}, {24'h0, m_out()});
            check("rand_oe", {24'h0, oe_o[t]}, {24'h0, m_dir});
            check("rand_irq", {31'h0, irq_o[t]}, {31'h0, m_irq[t]});
            check("rand_rd", rd[t], m_read(address, t));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = $urandom_range(0, 1) == 1;
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'($urandom);
            tick();
            check_all();
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        int         last_chg;
        int         n_chg;
        logic       prevb;

        vecs[0] = '{3'd1, 32'hFF, 8'hA5};
        vecs[1] = '{3'd0, 32'h0F, 8'h0F};
        vecs[2] = '{3'd4, 32'h30, 8'h3F};
        vecs[3] = '{3'd5, 32'h01, 8'h3E};
        vecs[4] = '{3'd6, 32'hFF, 8'hC1};

        chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
        in_port = 8'h3C;
        do_reset();

        // Reset state
        check("reset_out", {24'h0, op[0]}, 32'hA5);
        check("reset_oe", {24'h0, oe_o[0]}, 32'h00);
        check("reset_irq", {31'h0, irq_o[0]}, 32'h0);
        tick(); tick();
        address = 3'd0; #1;
        check("reset_rd_in", rd[0], 32'h0000003C);

        // Write aliases, table-driven
        for (int i = 0; i < 5; i++) begin
            write_cycle(vecs[i].addr, vecs[i].wd);
            check("alias_out", {24'h0, op[0]}, {24'h0, vecs[i].exp_out});
        end
        address = 3'd0; #1;
        check("alias_rd0", rd[0], 32'h000000C1);

        // Rising edge latency and interrupt
        in_port = 8'h00;
        repeat (4) tick();
        write_cycle(3'd3, 32'hFF);
        write_cycle(3'd2, 32'h04);
        address = 3'd3;
        tick();
        check("edge_pre", rd[0], 32'h0);
        in_port = 8'h04;
        tick(); check("edge_1clk", rd[0], 32'h0);
        tick(); check("edge_2clk", rd[0], 32'h0);
        tick(); check("edge_3clk", rd[0], 32'h04);
        check("irq_3clk", {31'h0, irq_o[0]}, 32'h0);
        tick(); check("irq_4clk", {31'h0, irq_o[0]}, 32'h1);
        write_cycle(3'd3, 32'h04);
        address = 3'd3; #1;
        check("clr_cap", rd[0], 32'h0);
        tick(); check("clr_irq", {31'h0, irq_o[0]}, 32'h0);

        // Edge coincident with write-1-to-clear: set wins
        in_port = 8'h00;
        repeat (4) tick();
        write_cycle(3'd3, 32'hFF);
        in_port = 8'h04;
        tick(); tick();
        write_cycle(3'd3, 32'h04);
        address = 3'd3; #1;
        check("coinc_cap", rd[0], 32'h04);
        tick(); check("coinc_irq", {31'h0, irq_o[0]}, 32'h1);
        tick(); check("coinc_irq_hold", {31'h0, irq_o[0]}, 32'h1);

        // Any-edge capture on a 5-clock pulse
        in_port = 8'h00;
        repeat (4) tick();
        write_cycle(3'd3, 32'hFF);
        address = 3'd3; #1;
        check("any_pre", rd[2], 32'h0);
        in_port = 8'h01;
        repeat (5) tick();
        in_port = 8'h00;
        repeat (4) tick();
        check("any_pulse", rd[2], 32'h01);
        write_cycle(3'd3, 32'h01);
        address = 3'd3;
        repeat (8) tick();
        check("any_hold", rd[2], 32'h0);

`ifdef PIO_BLINK_EN
        write_cycle(3'd0, 32'h03);
        write_cycle(3'd7, 32'h01);
        last_chg = -1; n_chg = 0; prevb = op[0][0];
        for (int i = 0; i < 24; i++) begin
            tick();
            check("blink_b1", {31'h0, op[0][1]}, 32'h1);
            if (op[0][0] != prevb) begin
                if (last_chg >= 0) check("blink_period", i - last_chg, 32'd4);
                last_chg = i; n_chg++; prevb = op[0][0];
            end
        end
        check("blink_toggles", {31'h0, n_chg >= 5}, 32'h1);
`else
        last_chg = 0; n_chg = 0; prevb = 1'b0;
        write_cycle(3'd7, 32'hFF);
        address = 3'd7; #1;
        for (int t = 0; t < 3; t++) check("addr7_rd", rd[t], 32'h0);
`endif

        // Randomised operation against the model
        random_phase(300);

        // Reset asserted mid-operation acts immediately
        write_cycle(3'd1, 32'hFF);
        write_cycle(3'd0, 32'h5A);
        address = 3'd1;
        #1 reset_n = 1'b0;
        #1;
        check("midrst_out", {24'h0, op[0]}, 32'hA5);
        check("midrst_oe", {24'h0, oe_o[0]}, 32'h0);
        check("midrst_rd1", rd[0], 32'h0);
        check("midrst_irq", {31'h0, irq_o[0]}, 32'h0);
        do_reset();
        random_phase(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
